// File: rtl/typing_round_controller.sv
// Sequences one timed typing round: primes the word library, checks keystrokes, counts words/mistakes.
// Optional MISTAKE_RESTART_EN: a wrong keystroke sends letter_idx back to the first letter.
module typing_round_controller #(
    parameter int LETTERS        = 4,
    parameter int LETTER_W       = 5,
    parameter int ROUND_WORDS    = 10,
    parameter int TIMEOUT_CYCLES = 1000000000,
    parameter int CNT_W          = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         key_valid,
    input  logic [LETTER_W-1:0]          key_code,
    input  logic [LETTERS*LETTER_W-1:0]  current_word,
    output logic                         word_advance,
    output logic [1:0]                   letter_idx,
    output logic                         letter_correct,
    output logic                         letter_wrong,
    output logic [CNT_W-1:0]             words_done,
    output logic [CNT_W-1:0]             mistakes,
    output logic                         busy,
    output logic                         round_over,
    output logic                         timed_out
);

    localparam int               TMR_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       IDX_LAST   = 2'(LETTERS - 1);
    localparam logic [CNT_W-1:0] WORDS_GOAL = CNT_W'(ROUND_WORDS);
    localparam logic [LETTER_W-1:0] CODE_MAX = LETTER_W'(25);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRIME_A = 3'd1,
        GAP_A   = 3'd2,
        PRIME_B = 3'd3,
        SETTLE  = 3'd4,
        TYPE    = 3'd5,
        ADV_GAP = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t             state_r;
    logic [TMR_W-1:0]   timer_r;
    logic               key_match_s;

    // Letter 0 sits in the most significant slice of the word.
    function automatic logic [LETTER_W-1:0] letter_at(
        input logic [LETTERS*LETTER_W-1:0] word,
        input logic [1:0]                  idx
    );
        letter_at = word[(LETTERS - 1 - int'(idx)) * LETTER_W +: LETTER_W];
    endfunction

    assign key_match_s = (key_code <= CODE_MAX) && (key_code == letter_at(current_word, letter_idx));

    // Round sequencer: state, timer, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            timer_r        <= '0;
            word_advance   <= 1'b0;
            letter_idx     <= 2'd0;
            letter_correct <= 1'b0;
            letter_wrong   <= 1'b0;
            words_done     <= '0;
            mistakes       <= '0;
            busy           <= 1'b0;
            round_over     <= 1'b0;
            timed_out      <= 1'b0;
        end else begin
            word_advance   <= 1'b0;
            letter_correct <= 1'b0;
            letter_wrong   <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r      <= PRIME_A;
                        word_advance <= 1'b1;
                        timer_r      <= '0;
                        letter_idx   <= 2'd0;
                        words_done   <= '0;
                        mistakes     <= '0;
                        busy         <= 1'b1;
                        round_over   <= 1'b0;
                        timed_out    <= 1'b0;
                    end
                end
                PRIME_A: state_r <= GAP_A;
                GAP_A: begin
                    state_r      <= PRIME_B;
                    word_advance <= 1'b1;
                end
                PRIME_B: state_r <= SETTLE;
                SETTLE:  state_r <= TYPE;
                TYPE, ADV_GAP: begin
                    // Timeout has priority over any keystroke arriving in the same cycle.
                    if (timer_r == TMR_LAST) begin
                        state_r    <= DONE;
                        busy       <= 1'b0;
                        round_over <= 1'b1;
                        timed_out  <= 1'b1;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                        if (state_r == ADV_GAP) begin
                            state_r <= TYPE;
                        end else if (key_valid && key_match_s) begin
                            letter_correct <= 1'b1;
                            if (letter_idx == IDX_LAST) begin
                                letter_idx <= 2'd0;
                                words_done <= words_done + CNT_W'(1);
                                if (words_done + CNT_W'(1) == WORDS_GOAL) begin
                                    state_r    <= DONE;
                                    busy       <= 1'b0;
                                    round_over <= 1'b1;
                                end else begin
                                    state_r      <= ADV_GAP;
                                    word_advance <= 1'b1;
                                end
                            end else begin
                                letter_idx <= letter_idx + 2'd1;
                            end
                        end else if (key_valid) begin
                            letter_wrong <= 1'b1;
                            if (mistakes != {CNT_W{1'b1}}) begin
                                mistakes <= mistakes + CNT_W'(1);
                            end
`ifdef MISTAKE_RESTART_EN
                            letter_idx <= 2'd0;
`else
                            letter_idx <= letter_idx;
`endif
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    busy       <= 1'b0;
                    round_over <= 1'b0;
                end
            endcase
        end
    end

endmodule
